// File: rtl/osd_pkg.sv
// Shared defaults and FSM state encoding for the OSD-2 frame scheduler.
package osd_pkg;

    localparam int N_DEF         = 64;
    localparam int K_DEF         = 32;
    localparam int BIT_WIDTH_DEF = 4;
    localparam int TAG_W_DEF     = 8;
    localparam int DEPTH_DEF     = 2;
    localparam int TIMEOUT_DEF   = 4096;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FLUSH  = 3'd3,
        HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/osd_frame_scheduler_if.sv
// Frame input, core side-band and result output bundle of the scheduler.
interface osd_frame_scheduler_if import osd_pkg::*; #(
    parameter int N         = N_DEF,
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int TAG_W     = TAG_W_DEF
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N*BIT_WIDTH-1:0] in_y;
    logic                   core_start;
    logic                   core_rst;
    logic [N*BIT_WIDTH-1:0] core_y;
    logic                   core_valid_out;
    logic [N-1:0]           core_chd;
    logic                   out_valid;
    logic                   out_ready;
    logic [N-1:0]           out_chd;
    logic [TAG_W-1:0]       out_tag;
    logic                   out_timeout;
    logic [15:0]            frames_done;
    logic                   busy;

    modport master (
        input  in_valid, in_y, core_valid_out, core_chd, out_ready,
        output in_ready, core_start, core_rst, core_y, out_valid, out_chd,
               out_tag, out_timeout, frames_done, busy
    );

    modport slave (
        output in_valid, in_y, core_valid_out, core_chd, out_ready,
        input  in_ready, core_start, core_rst, core_y, out_valid, out_chd,
               out_tag, out_timeout, frames_done, busy
    );

endinterface

// File: rtl/osd_frame_fifo.sv
// Register FIFO of {tag, frame} entries; the head is visible combinationally.
module osd_frame_fifo import osd_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = TAG_W_DEF + N_DEF * BIT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && (count_r < DEPTH_C);
    assign pop_ok_s  = pop && (count_r != '0);

    // Entry storage, cleared on reset so an empty FIFO presents a zero head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/osd_frame_scheduler.sv
// Launches one buffered frame at a time into the OSD-2 core, aborts hung
// decodes through a watchdog flush and returns tagged results in order.
module osd_frame_scheduler import osd_pkg::*; #(
    parameter int N         = N_DEF,
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int TAG_W     = TAG_W_DEF
) (
    input logic                   clk,
    input logic                   rst,
    osd_frame_scheduler_if.master bus
);
    localparam int Y_W   = N * BIT_WIDTH;
    localparam int E_W   = TAG_W + Y_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [TMR_W-1:0] timer_r;
    logic             flush_cnt_r;
    logic [TAG_W-1:0] tag_cnt_r;
    logic             core_start_r;
    logic             core_flush_r;
    logic             out_valid_r;
    logic [N-1:0]     out_chd_r;
    logic             out_timeout_r;
    logic [15:0]      frames_done_r;
    logic             start_s;
    logic             flush_s;
    logic             valid_s;
    logic             in_ready_s;
    logic             push_s;
    logic             hs_s;
    logic             more_s;
    logic [E_W-1:0]   head_s;
    logic [CNT_W-1:0] count_s;

    // Readiness uses the registered count only, so a full FIFO refuses a push
    // even in the cycle its head is popped.
    assign in_ready_s = (count_s < DEPTH_C);
    assign push_s     = bus.in_valid && in_ready_s;
    assign hs_s       = out_valid_r && bus.out_ready;
    assign more_s     = (count_s > ONE_C) || push_s;

    osd_frame_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (E_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({tag_cnt_r, bus.in_y}),
        .pop       (hs_s),
        .head      (head_s),
        .count     (count_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a result strobe beats the final watchdog cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (count_s != '0) next_state_s = LAUNCH;
                else               next_state_s = IDLE;
            end
            LAUNCH: next_state_s = WAIT;
            WAIT: begin
                if (bus.core_valid_out)      next_state_s = HOLD;
                else if (timer_r == TMR_LAST) next_state_s = FLUSH;
                else                          next_state_s = WAIT;
            end
            FLUSH: begin
                if (flush_cnt_r) next_state_s = HOLD;
                else             next_state_s = FLUSH;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (more_s) next_state_s = LAUNCH;
                    else        next_state_s = IDLE;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Moore output decode from the upcoming state, registered below.
    always_comb begin
        start_s = 1'b0;
        flush_s = 1'b0;
        valid_s = 1'b0;
        case (next_state_s)
            LAUNCH:  start_s = 1'b1;
            FLUSH:   flush_s = 1'b1;
            HOLD:    valid_s = 1'b1;
            default: start_s = 1'b0;
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_start_r <= 1'b0;
            core_flush_r <= 1'b0;
            out_valid_r  <= 1'b0;
        end else begin
            core_start_r <= start_s;
            core_flush_r <= flush_s;
            out_valid_r  <= valid_s;
        end
    end

    // Watchdog timer, flush-length counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r       <= '0;
            flush_cnt_r   <= 1'b0;
            out_chd_r     <= '0;
            out_timeout_r <= 1'b0;
        end else begin
            if (state_r == LAUNCH) begin
                timer_r <= '0;
            end else if (state_r == WAIT) begin
                timer_r <= timer_r + 1'b1;
            end
            if (state_r == FLUSH) begin
                flush_cnt_r <= ~flush_cnt_r;
            end else begin
                flush_cnt_r <= 1'b0;
            end
            if ((state_r == WAIT) && bus.core_valid_out) begin
                out_chd_r     <= bus.core_chd;
                out_timeout_r <= 1'b0;
            end else if (state_r == FLUSH) begin
                out_chd_r     <= '0;
                out_timeout_r <= 1'b1;
            end
        end
    end

    // Tag and completion counters; both wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_cnt_r     <= '0;
            frames_done_r <= 16'd0;
        end else begin
            if (push_s) begin
                tag_cnt_r <= tag_cnt_r + 1'b1;
            end
            if (hs_s) begin
                frames_done_r <= frames_done_r + 16'd1;
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.core_start  = core_start_r;
    assign bus.core_rst    = rst | core_flush_r;
    assign bus.core_y      = head_s[Y_W-1:0];
    assign bus.out_valid   = out_valid_r;
    assign bus.out_chd     = out_chd_r;
    assign bus.out_tag     = head_s[E_W-1:Y_W];
    assign bus.out_timeout = out_timeout_r;
    assign bus.frames_done = frames_done_r;
    assign bus.busy        = (state_r != IDLE) || (count_s != '0);

endmodule

// File: doc/osd_frame_scheduler.md
# osd_frame_scheduler

Frame-level sequencer for the OSD-2 decoder core (sorter → GE → flipping → selector → re-encoder → CHD).
- Accepts received LLR frames through a valid/ready input, buffers them in a small FIFO and launches one frame at a time into the core.
- The core has no back-pressure and GE is multi-cycle, so only one frame may be in flight.
- Guards the core with a timeout watchdog that resets it on a hang, and returns results tagged and in order through a valid/ready output.

## Interface
Parameters:
- N, 64: codeword length
- BIT_WIDTH, 4: LLR width per symbol
- DEPTH, 2: input FIFO depth (power of two, ≥2)
- TIMEOUT, 4096: max WAIT cycles before abort (≥4)
- TAG_W, 8: frame tag width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  frame offered
- in_ready  out  1  FIFO can accept
- in_y  in  N*BIT_WIDTH  received frame
- core_start  out  1  one-cycle launch pulse (drives core valid)
- core_rst  out  1  core reset (rst OR watchdog flush)
- core_y  out  N*BIT_WIDTH  FIFO head, held stable until the result is accepted
- core_valid_out  in  1  core result strobe
- core_chd  in  N  core estimated codeword
- out_valid  out  1  result available
- out_ready  in  1  sink accepts
- out_chd  out  N  captured codeword
- out_tag  out  TAG_W  tag of the frame
- out_timeout  out  1  result is an abort
- frames_done  out  16  accepted results, wraps
- busy  out  1  state≠IDLE or FIFO non-empty

## Operation
- FIFO entry = {tag, y}. Push on in_valid&in_ready, writing tag = push counter (wraps at 2^TAG_W).
- in_ready = (count<DEPTH). It is computed from the registered count, so a push while full is refused even when a pop occurs in the same cycle.
- The head is popped on the output handshake only.
- FSM:
  - IDLE: FIFO non-empty → LAUNCH.
  - LAUNCH: core_start=1 for one cycle → WAIT; timer cleared to 0.
  - WAIT: on core_valid_out, capture core_chd into out_chd and set out_timeout=0 → HOLD. Otherwise timer==TIMEOUT-1 → FLUSH. Otherwise timer++.
  - FLUSH: two cycles with core_rst=1; out_chd=0, out_timeout=1 → HOLD.
  - HOLD: out_valid=1. On out_ready, pop, frames_done++, and go to LAUNCH if the FIFO still holds an entry after the pop, otherwise IDLE.
- out_tag is always the FIFO head tag.
- core_valid_out seen outside WAIT is ignored.
- core_valid_out coincident with timer==TIMEOUT-1: the valid result wins.
- Reset values: in_ready=1, core_start=0, core_rst=1 while rst, 0 after; out_valid=0, out_chd=0, out_tag=0, out_timeout=0, frames_done=0, busy=0. FIFO empty, state IDLE, tag counter 0.
- Async rst mid-operation discards all queued frames and any in-flight result.

## Timing
- Push at edge e0 → LAUNCH after e1 (core_start high e1–e2) → WAIT after e2.
- core_valid_out sampled at edge ek → out_valid high after ek.
- Handshake at edge h with the FIFO non-empty after the pop → core_start high during the cycle after h, giving a one-cycle gap between results.
- Timeout: core_rst high for the 2 cycles following the WAIT cycle where timer==TIMEOUT-1; out_valid rises on the next edge. Abort latency from core_start = TIMEOUT+3 cycles.
- out_valid, out_chd, out_tag and out_timeout hold stable while out_valid&!out_ready.
- core_start, core_rst and out_valid are registered outputs (Moore); in_ready and busy come from registered state/count only.

## Structure
- Package osd_pkg: defaults for N, K, BIT_WIDTH, TAG_W, and the state enum {IDLE, LAUNCH, WAIT, FLUSH, HOLD}.
- Sub-module osd_frame_fifo: DEPTH×(TAG_W+N*BIT_WIDTH) register FIFO with count, exposing the head combinationally.

## Test plan
- Single frame, core_valid_out 40 cycles after core_start with chd=0xA5A5… → out_valid, out_chd=0xA5A5…, out_tag=0, out_timeout=0, frames_done=1.
- Three frames offered back-to-back with DEPTH=2 → third frame sees in_ready=0 until the first output handshake. Tags 0,1,2 return in order with exactly one core_start per frame.
- TIMEOUT=16 and the core never responds → core_rst high 2 cycles after 16 WAIT cycles, then result with out_timeout=1 and out_chd=0. The next queued frame launches normally.
- out_ready held low for 10 cycles in HOLD → outputs stable, no core_start, a second queued frame stays queued. Releasing out_ready gives core_start the next cycle.
- core_valid_out on the cycle where timer==TIMEOUT-1 → normal result with out_timeout=0. core_valid_out pulses during IDLE and HOLD → ignored, frames_done unchanged.
- Async rst asserted in WAIT with 2 frames queued → all outputs at reset values immediately, in_ready=1, busy=0, and the first post-reset frame gets tag 0.
